// File: rtl/mac_bist_pkg.sv
// mac_bist_pkg: shared types and constants for the MAC built-in self-test.
// Latency: n/a (types, constants and the LFSR step function only).
// Backpressure: n/a.
package mac_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int A_W = 8;
    localparam int B_W = 8;
    localparam int C_W = 16;

    localparam logic [31:0] LFSR_SEED = 32'hACE1_2468;
    // Right-shifting Galois taps for x^32 + x^22 + x^2 + x + 1.
    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

    localparam logic [7:0] ERR_MAX = 8'd255;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        lfsr_step = {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 32'h0);
    endfunction

endpackage

// File: rtl/mac_bist_lfsr.sv
// mac_bist_lfsr: 32-bit Galois LFSR operand source for the MAC self-test.
// Latency: value_o updates one cycle after advance/reseed.
// Backpressure: none; holds its value while advance is low.
// Ports: clk, rst (async, active-high), advance (step once), reseed (load seed;
// combined with advance it loads the state one step past the seed), value_o.
module mac_bist_lfsr
    import mac_bist_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        advance,
    input  logic        reseed,
    output logic [31:0] value_o
);

    logic [31:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (reseed) begin
            lfsr_d = advance ? lfsr_step(LFSR_SEED) : LFSR_SEED;
        end else if (advance) begin
            lfsr_d = lfsr_step(lfsr_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign value_o = lfsr_q;

endmodule

// File: rtl/mac_bist.sv
// mac_bist: drives LFSR operand vectors into an 8x8+16 MAC and checks o_i after LAT cycles.
// Latency: vector k on a_o/b_o/ci_o at start+1+k, checked at start+1+k+LAT, done at start+1+NUM_VEC+LAT.
// Backpressure: none; one vector per cycle while busy, start ignored unless IDLE or DONE.
// Ports: clk, rst (async, active-high), start, a_o/b_o/ci_o (to MAC), o_i (from MAC),
// busy, done, pass, err_cnt (saturating), vec_cnt. Optional macro MAC_BIST_FIRST_ERR_EN
// adds first_idx/first_exp/first_got describing the first mismatch of a run.
module mac_bist
    import mac_bist_pkg::*;
#(
    parameter int NUM_VEC = 256,
    parameter int LAT     = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    output logic [A_W-1:0] a_o,
    output logic [B_W-1:0] b_o,
    output logic [C_W-1:0] ci_o,
    input  logic [C_W-1:0] o_i,
    output logic           busy,
    output logic           done,
    output logic           pass,
    output logic [7:0]     err_cnt,
    output logic [15:0]    vec_cnt
`ifdef MAC_BIST_FIRST_ERR_EN
    ,
    output logic [15:0]    first_idx,
    output logic [15:0]    first_exp,
    output logic [15:0]    first_got
`endif
);

    localparam logic [15:0] NV     = 16'(NUM_VEC);
    localparam logic [2:0]  LAT_M1 = 3'(LAT - 1);

    state_t          state_q, state_d;
    logic [A_W-1:0]  a_q, a_d;
    logic [B_W-1:0]  b_q, b_d;
    logic [C_W-1:0]  ci_q, ci_d;
    logic [15:0]     vec_cnt_q, vec_cnt_d;
    logic [2:0]      drain_q, drain_d;
    logic [7:0]      err_q, err_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    // High in the cycle right after a vector was placed on the outputs.
    logic            issue_q, issue_d;
    logic            vld_q [LAT];
    logic            vld_d [LAT];
    logic [C_W-1:0]  exp_q [LAT];
    logic [C_W-1:0]  exp_d [LAT];

    logic            start_ok;
    logic            mismatch;
    logic [31:0]     lfsr_val;
    logic [31:0]     src;
    logic [C_W-1:0]  prod;

    mac_bist_lfsr u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .advance (issue_d),
        .reseed  (start_ok),
        .value_o (lfsr_val)
    );

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        ci_d      = ci_q;
        vec_cnt_d = vec_cnt_q;
        drain_d   = drain_q;
        err_d     = err_q;
        issue_d   = 1'b0;

        start_ok = start && (state_q == ST_IDLE || state_q == ST_DONE);
        // The first vector of a run is the seed itself, bypassing the LFSR register.
        src      = start_ok ? LFSR_SEED : lfsr_val;
        prod     = C_W'(a_q) * C_W'(b_q);
        mismatch = vld_q[LAT-1] && (o_i != exp_q[LAT-1]);

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_ok) begin
                    state_d   = ST_RUN;
                    issue_d   = 1'b1;
                    vec_cnt_d = 16'd1;
                end
            end
            ST_RUN: begin
                // vec_cnt counts the vector currently on the outputs.
                if (vec_cnt_q == NV) begin
                    state_d = ST_DRAIN;
                    drain_d = 3'd0;
                end else begin
                    issue_d   = 1'b1;
                    vec_cnt_d = vec_cnt_q + 16'd1;
                end
            end
            ST_DRAIN: begin
                if (drain_q == LAT_M1) begin
                    state_d = ST_DONE;
                end else begin
                    drain_d = drain_q + 3'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (issue_d) begin
            a_d  = src[A_W-1:0];
            b_d  = src[A_W+B_W-1:A_W];
            ci_d = src[31:A_W+B_W];
        end

        // Expected value enters the pipe the cycle after issue, so after LAT
        // stages it lines up with the MAC result LAT cycles after the operands.
        vld_d[0] = issue_q;
        exp_d[0] = prod + ci_q;
        for (int i = 1; i < LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            exp_d[i] = exp_q[i-1];
        end

        if (mismatch && err_q != ERR_MAX) begin
            err_d = err_q + 8'd1;
        end

        if (start_ok) begin
            err_d = 8'd0;
            for (int i = 0; i < LAT; i++) begin
                vld_d[i] = 1'b0;
                exp_d[i] = '0;
            end
        end

        busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
        done_d = (state_d == ST_DONE);
        pass_d = done_d && (err_d == 8'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            ci_q      <= '0;
            vec_cnt_q <= '0;
            drain_q   <= '0;
            err_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            issue_q   <= 1'b0;
            for (int i = 0; i < LAT; i++) begin
                vld_q[i] <= 1'b0;
                exp_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            ci_q      <= ci_d;
            vec_cnt_q <= vec_cnt_d;
            drain_q   <= drain_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            issue_q   <= issue_d;
            for (int i = 0; i < LAT; i++) begin
                vld_q[i] <= vld_d[i];
                exp_q[i] <= exp_d[i];
            end
        end
    end

    assign a_o     = a_q;
    assign b_o     = b_q;
    assign ci_o    = ci_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign pass    = pass_q;
    assign err_cnt = err_q;
    assign vec_cnt = vec_cnt_q;

`ifdef MAC_BIST_FIRST_ERR_EN
    logic [15:0] cmp_idx_q, cmp_idx_d;
    logic [15:0] first_idx_q, first_idx_d;
    logic [15:0] first_exp_q, first_exp_d;
    logic [15:0] first_got_q, first_got_d;
    logic        seen_q, seen_d;

    always_comb begin
        cmp_idx_d   = cmp_idx_q;
        first_idx_d = first_idx_q;
        first_exp_d = first_exp_q;
        first_got_d = first_got_q;
        seen_d      = seen_q;
        // cmp_idx is the index of the vector being compared this cycle.
        if (vld_q[LAT-1]) begin
            cmp_idx_d = cmp_idx_q + 16'd1;
        end
        if (mismatch && !seen_q) begin
            seen_d      = 1'b1;
            first_idx_d = cmp_idx_q;
            first_exp_d = exp_q[LAT-1];
            first_got_d = o_i;
        end
        if (start_ok) begin
            cmp_idx_d   = '0;
            first_idx_d = '0;
            first_exp_d = '0;
            first_got_d = '0;
            seen_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmp_idx_q   <= '0;
            first_idx_q <= '0;
            first_exp_q <= '0;
            first_got_q <= '0;
            seen_q      <= 1'b0;
        end else begin
            cmp_idx_q   <= cmp_idx_d;
            first_idx_q <= first_idx_d;
            first_exp_q <= first_exp_d;
            first_got_q <= first_got_d;
            seen_q      <= seen_d;
        end
    end

    assign first_idx = first_idx_q;
    assign first_exp = first_exp_q;
    assign first_got = first_got_q;
`endif

endmodule
